uart_rx_unit: RTL

//  Serial UART receiver sitting directly upstream of the MIPS core's memory-mapped Rx register.

---
 rtl/uart_rx_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_unit.sv
// rtl/uart_rx_unit.sv - UART receiver (8N1) with sticky byte flag, framing/overrun status.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_unit #(
  parameter int Nbit     = 8,
  parameter int clk_freq = 50,
  parameter int baudrate = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            SerialDataIn,
  input  logic            clr_rx_flag,
  output logic [Nbit-1:0] DataRx,
  output logic            Rx_flag,
  output logic            frame_err,
  output logic            overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int BIT_TICKS = clk_freq / baudrate;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int CW        = $clog2(BIT_TICKS);
  localparam int BW        = $clog2(Nbit + 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(Nbit - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bitcnt;
  logic [Nbit-1:0] shreg;
  logic            rx_meta, rx_s;
  logic            wait_high;
  logic            half_hit, bit_hit;
  logic            data_sample, stop_sample, good_frame;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
`endif

  assign half_hit    = (cnt == HALF_END);
  assign bit_hit     = (cnt == BIT_END);
  assign data_sample = (state == DATA) && bit_hit;
  assign stop_sample = (state == STOP) && bit_hit;
  assign good_frame  = stop_sample && rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= SerialDataIn;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      // After a framing error the line must return high before a new start bit counts.
      IDLE:   if (!wait_high && !rx_s) next_state = START;
      START:  if (half_hit) next_state = rx_s ? IDLE : DATA;
      DATA:   if (bit_hit && bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                next_state = PARITY;
`else
                next_state = STOP;
`endif
              end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_hit) next_state = STOP;
`endif
      STOP:   if (bit_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      wait_high <= 1'b0;
    end else begin
      if (next_state != state || bit_hit) cnt <= '0;
      else                                cnt <= cnt + 1'b1;

      if (state != DATA)    bitcnt <= '0;
      else if (data_sample) bitcnt <= bitcnt + 1'b1;

      if (data_sample) shreg <= {rx_s, shreg[Nbit-1:1]};

      if (stop_sample && !rx_s)       wait_high <= 1'b1;
      else if (state == IDLE && rx_s) wait_high <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DataRx    <= '0;
      Rx_flag   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rx_s;
      if (good_frame) DataRx <= shreg;
      // A completing frame beats a simultaneous clear.
      if (good_frame)       Rx_flag <= 1'b1;
      else if (clr_rx_flag) Rx_flag <= 1'b0;
      if (clr_rx_flag)                overrun <= 1'b0;
      else if (good_frame && Rx_flag) overrun <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && bit_hit) par_bad <= ^{shreg, rx_s};
      parity_err <= good_frame && par_bad;
    end
  end
`endif

endmodule
